mul_sched: RTL

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_pkg.sv | 16 +
 rtl/mul_rr_arb.sv | 36 +++
 rtl/mul_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the mul_sched multiplier scheduler.
// Contents: FSM state enum, requester-id type, bit-counter width.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  // Wide enough to count the MUL steps for WIDTH up to 16.
  localparam int CNT_W = 5;

endpackage

// File: rtl/mul_rr_arb.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   valid0, valid1  - request valids
//   accept          - a grant was taken this cycle; updates last-grant
//   grant0, grant1  - one-hot grant (both low when nobody requests)
//   grant_id        - index of the granted requester
module mul_rr_arb
  import mul_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid0,
  input  logic    valid1,
  input  logic    accept,
  output logic    grant0,
  output logic    grant1,
  output req_id_t grant_id
);

  req_id_t last;

  // last resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant_id;
    end
  end

  assign grant0   = valid0 && (!valid1 || (last == 1'b1));
  assign grant1   = valid1 && (!valid0 || (last == 1'b0));
  assign grant_id = grant1;

endmodule

// File: rtl/mul_sched.sv
// Two-requester shift-add multiplier scheduler.
// Accepts an operand pair from one of two requesters (round-robin), runs a
// one-bit-per-cycle shift-add multiply and presents the full product.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req{0,1}_valid/_a/_b/_ready     - requester operand handshakes
//   rsp_valid/rsp_ready             - result handshake
//   rsp_id, rsp_product             - owning requester, 2*WIDTH product
//   busy                            - high whenever not IDLE
// Optional build macro: MUL_SCHED_EARLY_EXIT_EN - leave MUL as soon as the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for a request, ready driven to the granted requester
// MUL   | one shift-add step per cycle
// DONE  | product valid, held until rsp_ready
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  req_id_t            id;
  logic               grant0, grant1, accept, last_step;
  req_id_t            grant_id;

  mul_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .accept   (accept),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  // rst_n gates ready so both readies read low for the whole reset pulse.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef MUL_SCHED_EARLY_EXIT_EN
  // Bits above the LSB are what remains after this step's shift.
  assign last_step = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_step = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = MUL;
      end
      MUL: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, (grant_id ? req1_a : req0_a)};
            mplier <= grant_id ? req1_b : req0_b;
            id     <= grant_id;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_product = acc;
  assign rsp_id      = id;
  assign busy        = (state != IDLE);

endmodule
